// File: rtl/regfile_dump_streamer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_dbg_pkg
// Shared definitions for the register-file dump streamer and its benches:
//   - NUM_REGS / ADDR_W / DATA_W : default register file geometry
//   - SP_RESET                   : reset value of x2 (stack pointer)
//   - state_t                    : dump engine states
// -----------------------------------------------------------------------------
package regfile_dbg_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [31:0] SP_RESET = 32'h2ffc;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_dump_streamer_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_streamer_if
// Valid/ready word stream carrying one register value per beat.
//   out_valid : producer holds a word
//   out_ready : consumer accepts when out_valid && out_ready at a rising edge
//   out_data  : register value
//   out_index : register index of out_data
//   out_last  : beat carries the final register
// Modports: master (producer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface regfile_dump_streamer_if #(
  parameter int ADDR_W = regfile_dbg_pkg::ADDR_W,
  parameter int DATA_W = regfile_dbg_pkg::DATA_W
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_streamer.sv
// -----------------------------------------------------------------------------
// regfile_dump_streamer
// Debug read-out engine: on a start pulse it walks every architectural register
// through an asynchronous read port, streams each word with its index, keeps an
// XOR checksum of accepted words and raises busy (CPU freeze) while dumping.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : one-cycle dump request, honoured only when idle
//   rf_addr  : read address to the register file (combinational from state)
//   rf_data  : asynchronous read data for rf_addr
//   stream   : word stream (master side)
//   busy     : high while streaming and in the finish cycle
//   done     : one-cycle pulse when the dump completes
//   checksum : XOR of all accepted words, stable from done until next start
// -----------------------------------------------------------------------------
module regfile_dump_streamer #(
  parameter int NUM_REGS = regfile_dbg_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_dbg_pkg::ADDR_W,
  parameter int DATA_W   = regfile_dbg_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic [DATA_W-1:0]     rf_data,
  regfile_dump_streamer_if.master stream,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum
);

  import regfile_dbg_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              hs;

  assign idx_nxt = idx + 1'b1;
  assign hs      = stream.out_valid && stream.out_ready;

  // The read port always looks one register ahead of the word being offered,
  // so the next word is ready to capture on the handshake edge. idx saturates
  // at the last register, so the lookahead stops there.
  always_comb begin
    rf_addr = '0;
    case (state)
      STREAM:  rf_addr = (idx < LAST_IDX) ? idx_nxt : idx;
      FINISH:  rf_addr = idx;
      default: rf_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      idx              <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      stream.out_data  <= '0;
      stream.out_index <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      checksum         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            stream.out_data  <= rf_data;
            stream.out_index <= '0;
            stream.out_valid <= 1'b1;
            stream.out_last  <= (LAST_IDX == '0);
            checksum         <= '0;
            idx              <= '0;
            busy             <= 1'b1;
            state            <= STREAM;
          end
        end

        STREAM: begin
          // Without a handshake every output holds; that is the stall.
          if (hs) begin
            checksum <= checksum ^ stream.out_data;
            if (idx == LAST_IDX) begin
              stream.out_valid <= 1'b0;
              stream.out_last  <= 1'b0;
              done             <= 1'b1;
              state            <= FINISH;
            end else begin
              idx              <= idx_nxt;
              stream.out_data  <= rf_data;
              stream.out_index <= idx_nxt;
              stream.out_last  <= (idx_nxt == LAST_IDX);
            end
          end
        end

        FINISH: begin
          // start is deliberately not looked at here; only IDLE accepts it.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
module tb_regfile_dump_streamer;
  import regfile_dbg_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  logic [DATA_W-1:0] exp_w  [NUM_REGS];
  logic [DATA_W-1:0] exp_sum;

  int checks   = 0;
  int failures = 0;

  regfile_dump_streamer_if os_if ();

  regfile_dump_streamer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .stream   (os_if),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // Register file model: asynchronous read, x0 hardwired to zero.
  assign rf_data = (rf_addr == '0) ? '0 : rf_mem[rf_addr];

  // Reference: the dump is the register image at start time, in index order,
  // and the checksum is the XOR of that image.
  task automatic snapshot();
    exp_sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_w[i] = (i == 0) ? '0 : rf_mem[i];
      exp_sum  = exp_sum ^ exp_w[i];
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom();
  endtask

  // mode: 0 ready high, 1 stalls at cycles 3-6 then alternating, 2 random,
  //       3 ready held low for 20 cycles at the last word.
  // restart_at: index at which to pulse start mid-dump (-2: pulse during done).
  // poke_at: index at which an already-captured register (x2) is overwritten.
  task automatic run_dump(input int mode, input int restart_at, input int poke_at);
    int                k;
    int                cyc;
    int                stalls;
    int                hold;
    int                dones;
    bit                restarted;
    bit                done_seen;
    logic              rdy;
    logic [ADDR_W-1:0] ea;
    snapshot();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || os_if.out_valid !== 1'b0 || rf_addr !== '0) begin
      failures++;
      $display("FAIL idle_before_start busy=%b done=%b valid=%b addr=%0d required 0 0 0 0",
               busy, done, os_if.out_valid, rf_addr);
    end
    start = 1'b1;
    os_if.out_ready = 1'b1;
    @(negedge clk);
    k = 0; cyc = 0; stalls = 0; hold = 0; dones = 0;
    restarted = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      start = 1'b0;
      if (done === 1'b1) begin
        done_seen = 1'b1;
        dones++;
        checks++;
        if (k != NUM_REGS) begin
          failures++;
          $display("FAIL words_accepted got=%0d required=%0d", k, NUM_REGS);
        end
        checks++;
        if (checksum !== exp_sum) begin
          failures++;
          $display("FAIL checksum got=%h required=%h", checksum, exp_sum);
        end
        checks++;
        if (cyc != NUM_REGS + stalls) begin
          failures++;
          $display("FAIL done_latency got=%0d required=%0d", cyc, NUM_REGS + stalls);
        end
        checks++;
        if (busy !== 1'b1 || os_if.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL finish_flags busy=%b valid=%b required 1 0", busy, os_if.out_valid);
        end
        if (restart_at == -2) start = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1 || os_if.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stream_flags k=%0d busy=%b valid=%b required 1 1", k, busy, os_if.out_valid);
        end
        if (k < NUM_REGS) begin
          ea = (k < NUM_REGS - 1) ? ADDR_W'(k + 1) : ADDR_W'(k);
          checks++;
          if (os_if.out_index !== ADDR_W'(k) || os_if.out_data !== exp_w[k] ||
              os_if.out_last !== 1'(k == NUM_REGS - 1) || rf_addr !== ea) begin
            failures++;
            $display("FAIL word k=%0d idx=%0d data=%h last=%b addr=%0d required idx=%0d data=%h last=%b addr=%0d",
                     k, os_if.out_index, os_if.out_data, os_if.out_last, rf_addr,
                     k, exp_w[k], (k == NUM_REGS - 1), ea);
          end
        end else begin
          checks++;
          failures++;
          $display("FAIL overrun extra word idx=%0d after %0d accepted", os_if.out_index, k);
        end
        case (mode)
          1:       rdy = (cyc >= 3 && cyc <= 6) ? 1'b0 : ((cyc >= 7) ? 1'(cyc % 2) : 1'b1);
          2:       rdy = 1'($urandom_range(0, 1));
          3:       begin
                     if (k == NUM_REGS - 1 && hold < 20) begin
                       rdy = 1'b0;
                       hold++;
                     end else begin
                       rdy = 1'b1;
                     end
                   end
          default: rdy = 1'b1;
        endcase
        if (restart_at == k && !restarted) begin
          start = 1'b1;
          restarted = 1'b1;
        end
        if (poke_at == k) rf_mem[2] = ~rf_mem[2];
        os_if.out_ready = rdy;
        if (rdy) k++;
        else stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL done_timeout accepted=%0d cycles=%0d required done", k, cyc);
    end else begin
      if (done === 1'b1) dones++;
      if (dones != 1 || busy !== 1'b0 || os_if.out_valid !== 1'b0 || checksum !== exp_sum) begin
        failures++;
        $display("FAIL after_done dones=%0d busy=%b valid=%b sum=%h required 1 0 0 %h",
                 dones, busy, os_if.out_valid, checksum, exp_sum);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || checksum !== exp_sum) begin
      failures++;
      $display("FAIL idle_hold busy=%b done=%b sum=%h required 0 0 %h", busy, done, checksum, exp_sum);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    os_if.out_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || os_if.out_valid !== 1'b0 || os_if.out_last !== 1'b0 ||
        os_if.out_data !== '0 || os_if.out_index !== '0 || checksum !== '0 || rf_addr !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b valid=%b last=%b data=%h idx=%0d sum=%h addr=%0d required all 0",
               busy, done, os_if.out_valid, os_if.out_last, os_if.out_data, os_if.out_index, checksum, rf_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || os_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b valid=%b required 0 0", busy, os_if.out_valid);
    end
  endtask

  task automatic test_sp_image();
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    rf_mem[2] = SP_RESET;
    run_dump(0, -1, -1);
    checks++;
    if (checksum !== SP_RESET) begin
      failures++;
      $display("FAIL sp_checksum got=%h required=%h", checksum, SP_RESET);
    end
  endtask

  task automatic test_pattern();
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'(i) * 32'h01010101;
    run_dump(0, -1, -1);
  endtask

  task automatic test_backpressure();
    fill_random();
    run_dump(1, -1, -1);
  endtask

  task automatic test_random_ready();
    fill_random();
    run_dump(2, -1, -1);
  endtask

  task automatic test_restart_mid();
    fill_random();
    run_dump(0, 10, 12);
  endtask

  task automatic test_start_at_finish();
    fill_random();
    run_dump(0, -2, -1);
  endtask

  task automatic test_reset_mid_dump();
    int n;
    fill_random();
    @(negedge clk);
    start = 1'b1;
    os_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (os_if.out_index !== ADDR_W'(17) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL reach_index17 timeout idx=%0d required 17", os_if.out_index);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (os_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || checksum !== '0 ||
        os_if.out_index !== '0 || rf_addr !== '0) begin
      failures++;
      $display("FAIL async_reset valid=%b busy=%b done=%b sum=%h idx=%0d addr=%0d required all 0",
               os_if.out_valid, busy, done, checksum, os_if.out_index, rf_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    run_dump(0, -1, -1);
  endtask

  task automatic test_last_hold();
    fill_random();
    run_dump(3, -1, -1);
  endtask

  initial begin
    test_reset();
    test_sp_image();
    test_pattern();
    test_backpressure();
    test_random_ready();
    test_restart_mid();
    test_start_at_finish();
    test_reset_mid_dump();
    test_last_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
- Debug read-out engine on the register file's read side: on a start pulse it walks all 32 architectural registers through one asynchronous read port.
- Each word goes out on a valid/ready stream with its index.
- Accumulates an XOR checksum and asserts a CPU-freeze request while busy.
- Sits beside the register file, on a spare read port muxed in when busy, feeding the debug/halt dump path.

Parameters:
NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1)
ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS
DATA_W, 32, register word width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
start  input  1  one-cycle request to begin a dump; ignored unless IDLE
rf_addr  output  ADDR_W  register index driven to the register file read port (combinational from state)
rf_data  input  DATA_W  asynchronous read data for rf_addr, same cycle; x0 reads 0
out_valid  output  1  out_data/out_index/out_last hold a word
out_ready  input  1  sink accepts the word when out_valid && out_ready at a rising edge
out_data  output  DATA_W  register value
out_index  output  ADDR_W  register index of out_data
out_last  output  1  high with the word for index NUM_REGS-1
busy  output  1  high in STREAM and FINISH; used as CPU freeze (no RF writes while high)
done  output  1  one-cycle pulse in FINISH
checksum  output  DATA_W  XOR of all accepted words; stable from done until next start

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, idx=0.
  - out_valid, out_last, busy and done are 0.
  - out_data, out_index and checksum are 0.
- States:
  - IDLE: rf_addr=0. On start: out_data<=rf_data (index 0), out_index<=0, out_valid<=1, out_last<=(NUM_REGS==1), checksum<=0, idx<=0, go STREAM.
  - STREAM: rf_addr = idx+1 when idx<NUM_REGS-1, else idx.
    - Handshake (out_valid && out_ready): checksum<=checksum^out_data.
    - If idx==NUM_REGS-1: out_valid<=0, out_last<=0, go FINISH.
    - Otherwise: idx<=idx+1, out_data<=rf_data, out_index<=idx+1, out_valid stays 1, out_last<=(idx+1==NUM_REGS-1).
    - No handshake: every output holds (stall), rf_addr unchanged.
  - FINISH: done=1 for exactly one cycle, busy=1, go IDLE. checksum is final.
- Throughput and latency:
  - 1 word/cycle with out_ready held high.
  - First word valid the cycle after start; a full dump is NUM_REGS+1 cycles from start to done, with no stalls.
- Stream rules:
  - out_valid never drops without a handshake.
  - out_data and out_index are stable while stalled.
- Coherence:
  - Each word is sampled at its capture edge.
  - busy must hold off RF writes. If a write still occurs to an already-captured index, it is not reflected (no re-read).
- Boundaries:
  - start while busy: ignored, no restart.
  - start in the same cycle as FINISH: ignored; a new start is accepted from IDLE only.
  - idx never wraps; it saturates at NUM_REGS-1.
  - Reset asserted mid-dump: immediate return to IDLE, partial checksum discarded (0).
  - out_ready high while out_valid low: no effect.

Decomposition:
- Shared package `regfile_dbg_pkg`:
  - state enum {IDLE, STREAM, FINISH}
  - constants NUM_REGS=32, ADDR_W=5, DATA_W=32
  - SP_RESET=32'h2ffc (reset value of x2, used by benches)
- Single module; no sub-module needed. The output holding register is inline.

Test Plan:
- After reset, RF model with x2=0x2ffc, all other registers 0; start pulse with out_ready=1 -> 32 words over 32 consecutive cycles, indices 0..31; word 2 = 0x2ffc; out_last only on index 31; done one cycle later; checksum=0x2ffc; busy high from the cycle after start through the done cycle.
- RF preloaded xi=i*0x01010101 (x0=0), ready=1 -> out_data[i] matches for every i; checksum = XOR of all values; done exactly 33 cycles after start.
- Backpressure: out_ready low on cycles 3–6 and alternating thereafter -> no word lost or duplicated; out_data/out_index stable during every stall; checksum unchanged vs the no-stall run.
- start pulsed again at index 10 mid-dump -> ignored; sequence continues 11..31; exactly one done.
- Reset driven low asynchronously (between clock edges) at index 17 -> out_valid, busy, done and checksum read 0 before the next edge; next start produces a full dump from index 0.
- Sink holds ready=0 indefinitely at index 31 -> out_valid stays 1, out_last=1, no done until ready rises; then done pulses once.
